psum_accumulator: RTL

- Downstream consumer of the corelet output bus: col lanes of psum_bw-bit signed partial sums, one output pixel per beat.
- Accumulates partial sums across num_pass kernel passes into an internal buffer of depth entries, one entry per output pixel.
- After the last pass, drains the buffer to the output port with optional ReLU, under a valid/ready handshake.

---
 rtl/psum_accumulator_pkg.sv | 28 ++
 rtl/psum_lane_alu.sv | 50 +++++
 rtl/psum_accumulator.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/psum_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// psum_accumulator_pkg
// Shared definitions for the partial-sum accumulator:
//   - state_e   : controller state encoding (IDLE, ACCUM, DRAIN)
//   - DEF_*     : default geometry used by the top and the lane ALU
//   - laneLo()  : low bit index of a lane inside a packed lane bus
// Optional build macro: PSUM_ACC_SATURATE_EN (selects saturating lane adds
// in psum_lane_alu; wrap-around arithmetic when undefined).
// ---------------------------------------------------------------------------
package psum_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int DEF_COL     = 8;
  localparam int DEF_PSUM_BW = 16;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_PASS_BW = 4;

  // Lane i of a packed bus occupies [bw*(i+1)-1 : bw*i]
  function automatic int laneLo(input int lane, input int bw);
    return lane * bw;
  endfunction

endpackage

// File: rtl/psum_lane_alu.sv
// ---------------------------------------------------------------------------
// psum_lane_alu
// Combinational per-lane datapath of the accumulator.
//   acc_i     : current buffer entry for this lane (signed)
//   addend_i  : incoming partial sum for this lane (signed)
//   sum_o     : acc_i + addend_i, wrapped or saturated
//   drain_i   : buffer entry being drained
//   relu_en_i : clamp negative drain values to zero
//   drain_o   : drain_i after optional ReLU
// Macro PSUM_ACC_SATURATE_EN: when defined, sum_o saturates to the signed
// range of psum_bw; otherwise it wraps modulo 2^psum_bw.
// ---------------------------------------------------------------------------
module psum_lane_alu
  import psum_accumulator_pkg::*;
#(
  parameter int psum_bw = DEF_PSUM_BW
) (
  input  logic signed [psum_bw-1:0] acc_i,
  input  logic signed [psum_bw-1:0] addend_i,
  input  logic signed [psum_bw-1:0] drain_i,
  input  logic                      relu_en_i,
  output logic signed [psum_bw-1:0] sum_o,
  output logic signed [psum_bw-1:0] drain_o
);

`ifdef PSUM_ACC_SATURATE_EN
  logic signed [psum_bw:0] wideSum;

  // One extra bit exposes overflow: the top two bits disagree exactly when
  // the true sum is outside the lane range, and the top bit gives the sign.
  always_comb begin
    wideSum = {acc_i[psum_bw-1], acc_i} + {addend_i[psum_bw-1], addend_i};
    if (wideSum[psum_bw] != wideSum[psum_bw-1]) begin
      sum_o = wideSum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                               : {1'b0, {(psum_bw-1){1'b1}}};
    end else begin
      sum_o = wideSum[psum_bw-1:0];
    end
  end
`else
  always_comb begin
    sum_o = acc_i + addend_i;
  end
`endif

  always_comb begin
    drain_o = (relu_en_i && drain_i[psum_bw-1]) ? '0 : drain_i;
  end

endmodule

// File: rtl/psum_accumulator.sv
// ---------------------------------------------------------------------------
// psum_accumulator
// Accumulates col-lane signed partial sums over num_pass kernel passes into a
// depth-entry buffer (one entry per output pixel), then drains the buffer
// with optional ReLU under a valid/ready handshake.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   start            : job start pulse, honoured only in IDLE
//   num_pass         : pass count (0 treated as 1), latched on start
//   en_relu          : ReLU on drain, latched on start
//   in_data/in_valid : input beat (lane i at [psum_bw*(i+1)-1 : psum_bw*i])
//   in_ready         : high while accumulating
//   out_data/out_valid/out_ready : registered drain stream
//   busy             : job in progress
//   done             : one-cycle pulse after the final drain beat
// Macro PSUM_ACC_SATURATE_EN: saturating lane additions (see psum_lane_alu).
// ---------------------------------------------------------------------------
module psum_accumulator
  import psum_accumulator_pkg::*;
#(
  parameter int col     = DEF_COL,
  parameter int psum_bw = DEF_PSUM_BW,
  parameter int depth   = DEF_DEPTH,
  parameter int pass_bw = DEF_PASS_BW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [pass_bw-1:0]       num_pass,
  input  logic                     en_relu,
  input  logic [psum_bw*col-1:0]   in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [psum_bw*col-1:0]   out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int             W         = psum_bw * col;
  localparam int             AW        = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [AW-1:0]  LAST_ADDR = AW'(depth - 1);

  state_e              state_q;
  logic [AW-1:0]       addr_q;
  logic [pass_bw-1:0]  pass_q;
  logic [pass_bw-1:0]  lastPass_q;
  logic                relu_q;
  logic [W-1:0]        outData_q;
  logic                outValid_q;
  logic                done_q;

  logic [W-1:0]        mem [depth];

  logic                beat;
  logic                drainFire;
  logic [AW-1:0]       rdAddr_d;
  logic [W-1:0]        accSum;
  logic [W-1:0]        drainVal;

  assign beat      = (state_q == ACCUM) && in_valid;
  assign drainFire = (state_q == DRAIN) && outValid_q && out_ready;

  // Read one entry ahead on a handshake so the next beat is registered on
  // the same edge, keeping out_valid high back-to-back.
  assign rdAddr_d  = drainFire ? addr_q + AW'(1) : addr_q;

  genvar g;
  generate
    for (g = 0; g < col; g++) begin : gLane
      localparam int LO = laneLo(g, psum_bw);
      psum_lane_alu #(
        .psum_bw(psum_bw)
      ) uAlu (
        .acc_i    (mem[addr_q][LO +: psum_bw]),
        .addend_i (in_data[LO +: psum_bw]),
        .drain_i  (mem[rdAddr_d][LO +: psum_bw]),
        .relu_en_i(relu_q),
        .sum_o    (accSum[LO +: psum_bw]),
        .drain_o  (drainVal[LO +: psum_bw])
      );
    end
  endgenerate

  // Buffer is intentionally not reset: pass 0 of every job overwrites it.
  always_ff @(posedge clk) begin
    if (beat) begin
      mem[addr_q] <= (pass_q == '0) ? in_data : accSum;
    end
  end

  // Controller: job setup, input addressing/pass counting, drain stream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      pass_q     <= '0;
      lastPass_q <= '0;
      relu_q     <= 1'b0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= ACCUM;
            addr_q     <= '0;
            pass_q     <= '0;
            lastPass_q <= (num_pass == '0) ? '0 : num_pass - pass_bw'(1);
            relu_q     <= en_relu;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            if (addr_q == LAST_ADDR) begin
              addr_q <= '0;
              if (pass_q == lastPass_q) begin
                state_q <= DRAIN;
              end else begin
                pass_q <= pass_q + pass_bw'(1);
              end
            end else begin
              addr_q <= addr_q + AW'(1);
            end
          end
        end
        DRAIN: begin
          if (!outValid_q) begin
            outData_q  <= drainVal;
            outValid_q <= 1'b1;
          end else if (out_ready) begin
            if (addr_q == LAST_ADDR) begin
              outValid_q <= 1'b0;
              done_q     <= 1'b1;
              addr_q     <= '0;
              state_q    <= IDLE;
            end else begin
              addr_q    <= addr_q + AW'(1);
              outData_q <= drainVal;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign busy      = (state_q != IDLE);
  assign out_data  = outData_q;
  assign out_valid = outValid_q;
  assign done      = done_q;

endmodule
